// File: rtl/carryselect_pkg.sv
// rtl/carryselect_pkg.sv - shared constants and overflow helper for the carry-select add/sub datapath
package carryselect_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Signed overflow: both operands agree in sign but the result does not.
  function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cs_slice_adder.sv
// rtl/cs_slice_adder.sv - combinational ripple-carry slice used for each carry-select segment
module cs_slice_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  logic c;

  // Bit-serial ripple: each bit consumes the carry produced by the bit below it.
  always_comb begin
    sum = '0;
    c   = ci;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/carryselect8_addsub_pipe.sv
// rtl/carryselect8_addsub_pipe.sv - two-stage pipelined carry-select adder/subtractor with valid/ready flow control
import carryselect_pkg::*;

module carryselect8_addsub_pipe #(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SPLIT = WIDTH / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int HW = WIDTH - SPLIT;

  // Subtraction is a + ~b + ~borrow; the carry-out is inverted later to form the borrow.
  logic [WIDTH-1:0] b_eff;
  logic             c_in;
  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign c_in  = (op == OP_SUB) ? ~ci : ci;

  logic [SPLIT-1:0] lo_sum;
  logic             lo_co;
  logic [HW-1:0]    hi0_sum, hi1_sum;
  logic             hi0_co, hi1_co;

  cs_slice_adder #(.W(SPLIT)) u_lo (
    .a   (a[SPLIT-1:0]),
    .b   (b_eff[SPLIT-1:0]),
    .ci  (c_in),
    .sum (lo_sum),
    .co  (lo_co)
  );

  cs_slice_adder #(.W(HW)) u_hi0 (
    .a   (a[WIDTH-1:SPLIT]),
    .b   (b_eff[WIDTH-1:SPLIT]),
    .ci  (1'b0),
    .sum (hi0_sum),
    .co  (hi0_co)
  );

  cs_slice_adder #(.W(HW)) u_hi1 (
    .a   (a[WIDTH-1:SPLIT]),
    .b   (b_eff[WIDTH-1:SPLIT]),
    .ci  (1'b1),
    .sum (hi1_sum),
    .co  (hi1_co)
  );

  // Stage 1 state
  logic             v1;
  logic [SPLIT-1:0] lo_sum_q;
  logic             lo_co_q;
  logic [HW-1:0]    hi0_sum_q, hi1_sum_q;
  logic             hi0_co_q, hi1_co_q;
  logic             a_msb_q, b_msb_q, op_q;

  // Stage 2 state
  logic v2;

  logic ready1, ready2;
  assign ready2    = !v2 || out_ready;
  assign ready1    = !v1 || ready2;
  assign in_ready  = ready1;
  assign out_valid = v2;

  // Stage 2 select: the registered low carry picks the precomputed high candidate.
  logic [HW-1:0]    hi_sel;
  logic             hi_co_sel;
  logic [WIDTH-1:0] s_next;
  logic             co_next, ovf_next;
  assign hi_sel    = lo_co_q ? hi1_sum_q : hi0_sum_q;
  assign hi_co_sel = lo_co_q ? hi1_co_q  : hi0_co_q;
  assign s_next    = {hi_sel, lo_sum_q};
  assign co_next   = hi_co_sel ^ (op_q == OP_SUB);
  assign ovf_next  = calc_ovf(a_msb_q, b_msb_q, s_next[WIDTH-1]);

  // Stage 1 register: capture slice results on an input transfer, drain when stage 2 takes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      lo_sum_q  <= '0;
      lo_co_q   <= 1'b0;
      hi0_sum_q <= '0;
      hi1_sum_q <= '0;
      hi0_co_q  <= 1'b0;
      hi1_co_q  <= 1'b0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      op_q      <= OP_ADD;
    end else if (ready1) begin
      v1 <= in_valid;
      if (in_valid) begin
        lo_sum_q  <= lo_sum;
        lo_co_q   <= lo_co;
        hi0_sum_q <= hi0_sum;
        hi1_sum_q <= hi1_sum;
        hi0_co_q  <= hi0_co;
        hi1_co_q  <= hi1_co;
        a_msb_q   <= a[WIDTH-1];
        b_msb_q   <= b_eff[WIDTH-1];
        op_q      <= op;
      end
    end
  end

  // Stage 2 register: result holds while the sink stalls, and keeps stale data when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2  <= 1'b0;
      s   <= '0;
      co  <= 1'b0;
      ovf <= 1'b0;
    end else if (ready2) begin
      v2 <= v1;
      if (v1) begin
        s   <= s_next;
        co  <= co_next;
        ovf <= ovf_next;
      end
    end
  end

endmodule

// File: doc/carryselect8_addsub_pipe.md
Name: carryselect8_addsub_pipe

Overview:
- Two-stage pipelined 8-bit carry-select adder/subtractor with valid/ready handshakes on input and output.
- Complements the existing combinational carry-select adder: adds the subtract direction (a - b - borrow-in) and registered, flow-controlled operation.
- Sits between an operand source and a result sink in the arithmetic datapath.
- Throughput: one operation per cycle. Latency: 2 cycles.

Parameters:
- WIDTH, 8, operand width; must be even and at least 4.
- SPLIT, WIDTH/2, bit position where the carry-select boundary sits; the low slice is computed in stage 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transfer request.
- in_ready  output  1  block can accept operands this cycle.
- op  input  1  operation select: 0 = add, 1 = subtract.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in for add; borrow-in for subtract.
- out_valid  output  1  result available.
- out_ready  input  1  sink accepts the result.
- s  output  WIDTH  sum or difference.
- co  output  1  carry-out for add; borrow-out for subtract.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Handshakes:
  - An input transfer happens when in_valid && in_ready.
  - An output transfer happens when out_valid && out_ready.
  - a, b, op and ci are sampled only on an input transfer.
- Arithmetic:
  - Add: {co, s} = a + b + ci.
  - Subtract: computed as a + ~b + ~ci. Then s = (a - b - ci) mod 2^WIDTH, and co = borrow = NOT(internal carry), so co = 1 iff a < b + ci (unsigned).
  - ovf = (A_msb == B'_msb) && (s_msb != A_msb), where B' is the effective second operand (b for add, ~b for subtract).
- Stage 1 (registered):
  - Low slice result [SPLIT-1:0] and its carry.
  - Two high-slice candidates, one for carry=0 and one for carry=1, each with its carry-out.
  - MSB information needed for ovf.
  - Valid bit v1.
- Stage 2 (registered): selects the high-slice candidate using the stage-1 low carry, then registers s, co, ovf and v2 (v2 drives out_valid).
- Flow control:
  - ready2 = !v2 || out_ready.
  - ready1 = !v1 || ready2.
  - in_ready = ready1, combinational from out_ready and the valid bits; no combinational path from in_valid.
  - A stage loads when its upstream is valid and its ready is high; otherwise it holds its contents unchanged.
  - A valid bit clears when its content moves on and nothing new arrives.
- Output stability: while out_valid && !out_ready, s, co and ovf are held constant.
- Simultaneous events: transfer in and out in the same cycle with the pipeline full is allowed; throughput is 1 per cycle with no bubble.
- Full condition: v1 && v2 && !out_ready gives in_ready = 0, and no operand is lost.
- Empty condition: out_valid = 0 and s/co/ovf hold their last values; the sink must ignore them.
- Reset:
  - Values: v1 = v2 = 0, out_valid = 0, s = 0, co = 0, ovf = 0, and in_ready = 1 in the first cycle after reset.
  - Mid-operation: in-flight results are discarded, not emitted.
  - An input presented in a reset cycle is not accepted.
- Wrap-around: results wrap modulo 2^WIDTH. All-ones plus all-ones plus 1 gives s = all-ones, co = 1.

Decomposition:
- Package carryselect_pkg holds:
  - the WIDTH default;
  - op encodings OP_ADD = 0 and OP_SUB = 1;
  - a helper function for the ovf expression.
- Sub-module cs_slice_adder:
  - purely combinational ripple slice, parameterised width;
  - outputs sum and carry-out for a given carry-in;
  - instantiated three times: the low slice, plus the high slice with ci = 0 and with ci = 1.
- Top level contains only the pipeline registers, the select mux and the handshake logic.

Test Plan:
- Basic add:
  - Stimulus: a=5, b=10, ci=1, op=add, out_ready=1.
  - Response: s=16, co=0, ovf=0, with out_valid high exactly 2 cycles after acceptance.
- Subtract with borrow:
  - Stimulus: a=37, b=48, ci=0, op=sub.
  - Response: s=245, co=1, ovf=0.
- Signed overflow cases:
  - a=127, b=127, ci=1, add: response s=255, co=0, ovf=1.
  - a=100, b=200, ci=0, sub: response s=156, co=1, ovf=1.
- Back-to-back streaming:
  - Stimulus: 9 operations on consecutive cycles, including a=63, b=211, add; out_ready held 1.
  - Response: 9 results in order on consecutive cycles; for that pair s=18, co=1; in_ready never drops.
- Backpressure:
  - Stimulus: hold out_ready=0 and present 3 operations.
  - Response: the first 2 are accepted, then in_ready=0; s/co/ovf stay stable.
  - On release, results drain in order, then the 3rd operation is accepted.
- Reset mid-stream:
  - Stimulus: assert reset with both stages valid.
  - Response: next cycle out_valid=0, s=0, co=0, ovf=0, in_ready=1; the discarded results never appear at the output.
